// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state codes, baud
// divider calculation, counter-width helper and the 2-of-3 vote.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Rounded clk_sys cycles per oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        longint den;
        longint num;
        den = longint'(baud) * longint'(oversample);
        num = longint'(clk_hz) + (den / 64'sd2);
        return int'(num / den);
    endfunction

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2_f(input int value);
        int width;
        int rem;
        width = 32'sd0;
        rem   = value - 32'sd1;
        while (rem > 32'sd0) begin
            width = width + 32'sd1;
            rem   = rem >>> 1;
        end
        if (width < 32'sd1) begin
            width = 32'sd1;
        end
        return width;
    endfunction

    // 2-of-3 majority of the mid-bit samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: counts DIV clk_sys cycles per tick. A restart
// pulse zeroes the counter so the next tick lands DIV cycles later, which
// lets a receiver phase-align its ticks to a detected start edge.
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV = 54
) (
    input  logic clk_sys,
    input  logic rst_sys,
    input  logic restart,
    output logic tick
);

    localparam int            CW       = clog2_f(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] DIV_PRE  = CW'(DIV - 2);

    logic [CW-1:0] div_cnt_r;
    logic          tick_r;

    // Divider counter: wraps at DIV-1, forced to zero on restart.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            div_cnt_r <= '0;
        end else if (restart) begin
            div_cnt_r <= '0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + CW'(1);
        end
    end

    // Registered tick, high exactly while div_cnt_r == DIV-1.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            tick_r <= 1'b0;
        end else if (restart) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= (div_cnt_r == DIV_PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_rx_8n1_oversampled.sv
// 8N1 UART receiver. The line is synchronised, a falling edge in IDLE
// re-phases the oversample divider, and each bit is decided by a 2-of-3
// vote around mid-bit. Stop-bit failures raise frame error, and a frame
// error over an all-zero byte is additionally reported as a line break.
module uart_rx_8n1_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_sys,
    input  logic       rst_sys,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_vld,
    output logic       rx_frame_err,
    output logic       rx_break,
    output logic       rx_busy
);

    localparam int            DIV       = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int            SW        = clog2_f(OVERSAMPLE);
    localparam logic [SW-1:0] SAMP_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx_8n1_oversampled: clock too slow for BAUD*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
        $error("uart_rx_8n1_oversampled: OVERSAMPLE must be even and >= 8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("uart_rx_8n1_oversampled: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic [1:0]             state_r;
    logic [SW-1:0]          samp_idx_r;
    logic [2:0]             bit_idx_r;
    logic [7:0]             shreg_r;
    logic                   vote_lo_r;
    logic                   vote_mid_r;

    logic rx_s;
    logic fall_s;
    logic restart_s;
    logic tick_s;
    logic decide_s;
    logic bit_end_s;
    logic maj_s;

    assign rx_s      = sync_r[SYNC_STAGES-1];
    assign fall_s    = prev_r & ~rx_s;
    assign restart_s = (state_r == ST_IDLE) && fall_s;
    assign decide_s  = tick_s && (samp_idx_r == SAMP_HI);
    assign bit_end_s = tick_s && (samp_idx_r == SAMP_LAST);
    assign maj_s     = maj3(vote_lo_r, vote_mid_r, rx_s);

    uart_baud_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk_sys (clk_sys),
        .rst_sys (rst_sys),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Metastability chain on the raw line; resets to idle-high.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx_serial};
        end
    end

    // Previous synchronised sample, used to require a real falling edge.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= rx_s;
        end
    end

    // Capture the first two vote samples; the third is taken live at the decision tick.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            vote_lo_r  <= 1'b0;
            vote_mid_r <= 1'b0;
        end else if (tick_s && (samp_idx_r == SAMP_LO)) begin
            vote_lo_r  <= rx_s;
        end else if (tick_s && (samp_idx_r == SAMP_MID)) begin
            vote_mid_r <= rx_s;
        end else begin
            vote_lo_r  <= vote_lo_r;
            vote_mid_r <= vote_mid_r;
        end
    end

    // Frame FSM: start validation, data shift, stop check and result strobes.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_r      <= ST_IDLE;
            samp_idx_r   <= '0;
            bit_idx_r    <= 3'd0;
            shreg_r      <= 8'h00;
            rx_byte      <= 8'h00;
            rx_vld       <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_break     <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_vld       <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_break     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_r    <= ST_START;
                        samp_idx_r <= '0;
                        bit_idx_r  <= 3'd0;
                        rx_busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (decide_s && maj_s) begin
                        // Start bit did not hold low at mid-bit: treat as a glitch.
                        state_r    <= ST_IDLE;
                        samp_idx_r <= '0;
                        rx_busy    <= 1'b0;
                    end else if (bit_end_s) begin
                        state_r    <= ST_DATA;
                        samp_idx_r <= '0;
                        bit_idx_r  <= 3'd0;
                    end else if (tick_s) begin
                        samp_idx_r <= samp_idx_r + SW'(1);
                    end
                end
                ST_DATA: begin
                    if (decide_s) begin
                        shreg_r <= {maj_s, shreg_r[7:1]};
                    end
                    if (bit_end_s) begin
                        samp_idx_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else if (tick_s) begin
                        samp_idx_r <= samp_idx_r + SW'(1);
                    end
                end
                ST_STOP: begin
                    if (decide_s) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        if (maj_s) begin
                            rx_byte <= shreg_r;
                            rx_vld  <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                            rx_break     <= (shreg_r == 8'h00);
                        end
                        state_r    <= ST_IDLE;
                        samp_idx_r <= '0;
                        rx_busy    <= 1'b0;
                    end else if (tick_s) begin
                        samp_idx_r <= samp_idx_r + SW'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    samp_idx_r <= '0;
                    rx_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
